// File: rtl/rect_span_mask_builder_pkg.sv
// rect_span_mask_builder_pkg: shared pass/state types and geometry constants for the span mask builder
package rect_span_mask_builder_pkg;

    localparam int X_RES           = 640;
    localparam int Y_RES           = 480;
    localparam int RECTS_PER_BATCH = 16;
    localparam int BATCHES         = 4;
    localparam int XA_W            = 12;
    localparam int YA_W            = 11;

    typedef enum logic [2:0] {
        LEFT   = 3'd0,
        RIGHT  = 3'd1,
        TOP    = 3'd2,
        BOTTOM = 3'd3,
        COLOR  = 3'd4
    } pass_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Number of positions swept in a coordinate pass
    function automatic logic [9:0] pass_limit(input pass_t p);
        return (p == LEFT || p == RIGHT) ? 10'(X_RES) : 10'(Y_RES);
    endfunction

    // LEFT/RIGHT passes target the x-mask RAM, TOP/BOTTOM the y-mask RAM
    function automatic logic is_x_pass(input pass_t p);
        return p == LEFT || p == RIGHT;
    endfunction

endpackage

// File: rtl/rect_span_mask_builder_span_compare16.sv
// span_compare16: per-rect position-vs-bound compare producing a 16-bit coverage mask
module span_compare16
    import rect_span_mask_builder_pkg::*;
(
    input  logic [RECTS_PER_BATCH-1:0][9:0] bounds,
    input  logic [9:0]                      pos,
    input  logic                            ge_sel,
    input  logic [RECTS_PER_BATCH-1:0]      old_mask,
    input  logic                            and_en,
    output logic [RECTS_PER_BATCH-1:0]      mask
);

    // Leading edges use pos >= bound; trailing edges use pos < bound ANDed with the previous mask
    always_comb begin
        mask = '0;
        for (int i = 0; i < RECTS_PER_BATCH; i++)
            mask[i] = (ge_sel ? pos >= bounds[i] : pos < bounds[i]) & (~and_en | old_mask[i]);
    end

endmodule

// File: rtl/rect_span_mask_builder.sv
// rect_span_mask_builder: captures DMA rect batches and sweeps them into x/y coverage mask RAMs and the color file
module rect_span_mask_builder
    import rect_span_mask_builder_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_start,
    input  logic            coord_valid,
    input  logic [15:0]     coord_in,
    output logic [XA_W-1:0] xmask_raddr,
    output logic [XA_W-1:0] xmask_waddr,
    input  logic [15:0]     xmask_rdata,
    output logic [15:0]     xmask_wdata,
    output logic            xmask_we,
    output logic [YA_W-1:0] ymask_raddr,
    output logic [YA_W-1:0] ymask_waddr,
    input  logic [15:0]     ymask_rdata,
    output logic [15:0]     ymask_wdata,
    output logic            ymask_we,
    output logic [5:0]      color_waddr,
    output logic [15:0]     color_wdata,
    output logic            color_we,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun
);

    state_t                            state_q, state_d;
    pass_t                             pass_q, pass_d;
    logic [1:0]                        batch_q, batch_d;
    logic [3:0]                        index_q, index_d;
    logic [9:0]                        p_q, p_d;
    logic [RECTS_PER_BATCH-1:0][9:0]   coord_q, coord_d;
    logic [XA_W-1:0]                   addr_q, addr_d;
    logic                              overrun_q, overrun_d;
    logic                              frame_done_q, frame_done_d;

    logic [9:0]      limit;
    logic            x_axis;
    logic            ge_sel;
    logic            rd_issue;
    logic            wr_stage;
    logic [XA_W-1:0] rd_addr;
    logic [15:0]     old_mask;
    logic [15:0]     new_mask;

    // Sweep pipeline: read position p in cycle t, write it back in t+1 using the registered address
    assign limit    = pass_limit(pass_q);
    assign x_axis   = is_x_pass(pass_q);
    assign ge_sel   = pass_q == LEFT || pass_q == TOP;
    assign rd_issue = state_q == SWEEP && p_q != limit;
    assign wr_stage = state_q == SWEEP && p_q != 10'd0 && !frame_start;
    assign rd_addr  = XA_W'(batch_q) * XA_W'(limit) + XA_W'(p_q);
    assign old_mask = x_axis ? xmask_rdata : ymask_rdata;

    span_compare16 u_cmp (
        .bounds   (coord_q),
        .pos      (p_q - 10'd1),
        .ge_sel   (ge_sel),
        .old_mask (old_mask),
        .and_en   (!ge_sel),
        .mask     (new_mask)
    );

    assign xmask_raddr = (rd_issue && x_axis) ? rd_addr : '0;
    assign ymask_raddr = (rd_issue && !x_axis) ? rd_addr[YA_W-1:0] : '0;
    assign xmask_we    = wr_stage && x_axis;
    assign ymask_we    = wr_stage && !x_axis;
    assign xmask_waddr = xmask_we ? addr_q : '0;
    assign ymask_waddr = ymask_we ? addr_q[YA_W-1:0] : '0;
    assign xmask_wdata = xmask_we ? new_mask : '0;
    assign ymask_wdata = ymask_we ? new_mask : '0;

    // Colors bypass the coordinate buffer and go straight to the register file
    assign color_we    = state_q == LOAD && pass_q == COLOR && coord_valid && !frame_start;
    assign color_waddr = color_we ? {batch_q, index_q} : '0;
    assign color_wdata = color_we ? coord_in : '0;

    assign busy       = state_q != IDLE;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    // Sequencer next-state: frame_start aborts everything, LOAD buffers values, SWEEP walks positions
    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        batch_d      = batch_q;
        index_d      = index_q;
        p_d          = p_q;
        coord_d      = coord_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        addr_d       = rd_addr;
        if (frame_start) begin
            state_d   = LOAD;
            pass_d    = LEFT;
            batch_d   = 2'd0;
            index_d   = 4'd0;
            p_d       = 10'd0;
            overrun_d = 1'b0;
        end else if (state_q == LOAD && coord_valid) begin
            if (pass_q != COLOR)
                coord_d[index_q] = coord_in[9:0];
            index_d = index_q + 4'd1;
            if (index_q == 4'(RECTS_PER_BATCH - 1)) begin
                if (pass_q != COLOR) begin
                    state_d = SWEEP;
                    p_d     = 10'd0;
                end else begin
                    batch_d = batch_q + 2'd1;
                    if (batch_q == 2'(BATCHES - 1)) begin
                        state_d      = IDLE;
                        pass_d       = LEFT;
                        frame_done_d = 1'b1;
                    end
                end
            end
        end else if (state_q == SWEEP) begin
            overrun_d = overrun_q | coord_valid;
            p_d       = p_q + 10'd1;
            if (p_q == limit) begin
                p_d     = 10'd0;
                state_d = LOAD;
                batch_d = batch_q + 2'd1;
                pass_d  = (batch_q == 2'(BATCHES - 1)) ? pass_t'(pass_q + 3'd1) : pass_q;
            end
        end
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pass_q       <= LEFT;
            batch_q      <= 2'd0;
            index_q      <= 4'd0;
            p_q          <= 10'd0;
            coord_q      <= '0;
            addr_q       <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_q       <= pass_d;
            batch_q      <= batch_d;
            index_q      <= index_d;
            p_q          <= p_d;
            coord_q      <= coord_d;
            addr_q       <= addr_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_rect_span_mask_builder.sv
// tb_rect_span_mask_builder: directed frames with RAM/color models and immediate-assertion checks
module tb_rect_span_mask_builder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        coord_valid = 1'b0;
    logic [15:0] coord_in = '0;
    logic [11:0] xmask_raddr, xmask_waddr;
    logic [15:0] xmask_rdata, xmask_wdata;
    logic        xmask_we;
    logic [10:0] ymask_raddr, ymask_waddr;
    logic [15:0] ymask_rdata, ymask_wdata;
    logic        ymask_we;
    logic [5:0]  color_waddr;
    logic [15:0] color_wdata;
    logic        color_we;
    logic        busy, frame_done, overrun;

    rect_span_mask_builder dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .coord_valid (coord_valid),
        .coord_in    (coord_in),
        .xmask_raddr (xmask_raddr),
        .xmask_waddr (xmask_waddr),
        .xmask_rdata (xmask_rdata),
        .xmask_wdata (xmask_wdata),
        .xmask_we    (xmask_we),
        .ymask_raddr (ymask_raddr),
        .ymask_waddr (ymask_waddr),
        .ymask_rdata (ymask_rdata),
        .ymask_wdata (ymask_wdata),
        .ymask_we    (ymask_we),
        .color_waddr (color_waddr),
        .color_wdata (color_wdata),
        .color_we    (color_we),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] xmem [0:4095];
    logic [15:0] ymem [0:2047];
    logic [15:0] cregs [0:63];
    logic [15:0] vals [2][5][4][16];
    int          cyc = 0, cw_cyc = 0, fd_cyc = 0, fd_cnt = 0, xwe_y = 0;
    logic        fd_busy = 1'b0;
    logic        in_y = 1'b0;
    int          errors = 0, checks = 0;

    // Mask RAMs with 1-cycle read latency, color file, and frame_done/latency monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (xmask_we) xmem[xmask_waddr] <= xmask_wdata;
        if (ymask_we) ymem[ymask_waddr] <= ymask_wdata;
        xmask_rdata <= xmem[xmask_raddr];
        ymask_rdata <= ymem[ymask_raddr];
        if (color_we) cregs[color_waddr] <= color_wdata;
        if (color_we && color_waddr == 6'd63) cw_cyc <= cyc;
        if (frame_done) begin
            fd_cnt  <= fd_cnt + 1;
            fd_cyc  <= cyc;
            fd_busy <= busy;
        end
        if (in_y && xmask_we) xwe_y <= xwe_y + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] exp_mask(input int ps, input int b, input int p);
        logic [15:0] m;
        for (int i = 0; i < 16; i++)
            m[i] = (p >= int'(vals[0][ps][b][i][9:0])) && (p < int'(vals[0][ps+1][b][i][9:0]));
        return m;
    endfunction

    task automatic send_vals(input int f, input int ps, input int b);
        for (int i = 0; i < 16; i++) begin
            coord_valid = 1'b1;
            coord_in    = vals[f][ps][b][i];
            @(negedge clk);
        end
        coord_valid = 1'b0;
    endtask

    task automatic sweep_wait(input int n, input int ovr);
        for (int c = 0; c < n; c++) begin
            if (c == ovr) begin
                chk("xwe_in_xsweep", 32'(xmask_we), 1);
                chk("ywe_in_xsweep", 32'(ymask_we), 0);
                coord_valid = 1'b1;
                coord_in    = 16'h0155;
            end
            @(negedge clk);
            coord_valid = 1'b0;
            if (c == ovr) chk("overrun_set", 32'(overrun), 1);
        end
    endtask

    task automatic send_pass(input int f, input int ps, input int ovr);
        for (int b = 0; b < 4; b++) begin
            send_vals(f, ps, b);
            if (ps < 4) sweep_wait((ps < 2 ? 640 : 480) + 4, b == 0 ? ovr : -1);
        end
    endtask

    task automatic run_frame(input int f, input int ovr);
        send_pass(f, 0, ovr);
        send_pass(f, 1, -1);
        in_y = 1'b1;
        send_pass(f, 2, -1);
        send_pass(f, 3, -1);
        in_y = 1'b0;
        send_pass(f, 4, -1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input int fd_base, input logic exp_ovr);
        int bad;
        logic any4, all5;
        chk("x_p15", 32'(xmem[15]), 32'hFFE3);
        chk("x_p639", 32'(xmem[639]), 32'hFFE5);
        chk("x_p20", 32'(xmem[20]), 32'hFFE1);
        chk("x_p20_bit1", 32'(xmem[20][1]), 0);
        chk("x_b1_p0", 32'(xmem[640]), 32'h0001);
        chk("x_b1_p120", 32'(xmem[760]), 32'h000F);
        chk("x_b1_p639", 32'(xmem[1279]), 32'hFFFF);
        any4 = 1'b0;
        for (int p = 0; p < 640; p++) any4 |= xmem[p][4];
        chk("empty_rect_bit4", 32'(any4), 0);
        bad = 0;
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 640; p++)
                if (xmem[b*640+p] !== exp_mask(0, b, p)) bad++;
        chk("x_all_positions", bad, 0);
        chk("y_b3_p99", 32'(ymem[1539]), 32'hFFFE);
        chk("y_b3_p100", 32'(ymem[1540]), 32'hFFFF);
        chk("y_b3_p199", 32'(ymem[1639]), 32'hFFFF);
        chk("y_b3_p200", 32'(ymem[1640]), 32'hFFFE);
        all5 = 1'b1;
        for (int p = 0; p < 480; p++) all5 &= ymem[1440+p][5];
        chk("y_b3_bit5_all", 32'(all5), 1);
        bad = 0;
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 480; p++)
                if (ymem[b*480+p] !== exp_mask(2, b, p)) bad++;
        chk("y_all_positions", bad, 0);
        chk("xwe_during_y", xwe_y, 0);
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (cregs[k] !== 16'(k + 256)) bad++;
        chk("colors_all", bad, 0);
        chk("color_63", 32'(cregs[63]), 32'h013F);
        chk("frame_done_count", fd_cnt - fd_base, 1);
        chk("frame_done_latency", fd_cyc - cw_cyc, 1);
        chk("busy_at_done", 32'(fd_busy), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("overrun_end", 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        int fd_base;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 16; i++) begin
                vals[0][0][b][i] = (b == 1) ? 16'(i * 40) : 16'd0;
                vals[0][1][b][i] = 16'd640;
                vals[0][2][b][i] = 16'd0;
                vals[0][3][b][i] = 16'd480;
                vals[0][4][b][i] = 16'(16'h100 + b * 16 + i);
                for (int s = 0; s < 5; s++) vals[1][s][b][i] = 16'd300;
            end
        vals[0][0][0][1] = 16'd10;
        vals[0][0][0][2] = 16'hA27F;
        vals[0][0][0][3] = 16'd640;
        vals[0][0][0][4] = 16'd100;
        vals[0][1][0][1] = 16'd20;
        vals[0][1][0][4] = 16'd100;
        vals[0][2][3][0] = 16'd100;
        vals[0][3][3][0] = 16'd200;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_xwe", 32'(xmask_we), 0);
        chk("rst_ywe", 32'(ymask_we), 0);
        chk("rst_cwe", 32'(color_we), 0);
        chk("rst_xraddr", 32'(xmask_raddr), 0);
        chk("rst_yraddr", 32'(ymask_raddr), 0);

        coord_valid = 1'b1;
        coord_in    = 16'h0123;
        @(negedge clk);
        coord_valid = 1'b0;
        chk("idle_valid_overrun", 32'(overrun), 0);
        chk("idle_valid_busy", 32'(busy), 0);

        fd_base     = fd_cnt;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        run_frame(0, 300);
        check_frame(fd_base, 1'b1);

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("start_clears_overrun", 32'(overrun), 0);
        send_pass(1, 0, -1);
        send_vals(1, 1, 0);
        sweep_wait(200, 150);
        chk("xwe_before_abort", 32'(xmask_we), 1);
        frame_start = 1'b1;
        coord_valid = 1'b1;
        coord_in    = 16'h03FF;
        #1;
        chk("abort_xwe_same_cycle", 32'(xmask_we), 0);
        @(negedge clk);
        frame_start = 1'b0;
        coord_valid = 1'b0;
        chk("abort_xwe_next", 32'(xmask_we), 0);
        chk("abort_busy", 32'(busy), 1);
        chk("abort_overrun", 32'(overrun), 0);

        fd_base = fd_cnt;
        run_frame(0, -1);
        check_frame(fd_base, 1'b0);

        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        send_vals(0, 0, 0);
        sweep_wait(50, -1);
        chk("xwe_before_reset", 32'(xmask_we), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_sweep_xwe", 32'(xmask_we), 0);
        chk("reset_mid_sweep_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rect_span_mask_builder.md
Name: rect_span_mask_builder

Overview:
- GPU-side consumer of the rectangle DMA stream; sits directly downstream of the rect copy controller.
- Captures each batch of 16 clamped coordinates, then sweeps every column (0..639) or row (0..479) and writes per-position 16-bit coverage masks into the x-mask and y-mask RAMs.
- Stores colors into the 64-entry color register file.
- The pixel stage later combines x-mask AND y-mask plus colors.

Parameters:
- X_RES, 640, columns swept in left/right passes
- Y_RES, 480, rows swept in top/bottom passes
- BATCHES, 4, batches of 16 rects per pass (64 rects total)
- XA_W, 12, x-mask RAM address width (depth BATCHES*X_RES)
- YA_W, 11, y-mask RAM address width (depth BATCHES*Y_RES)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  pulse; tied to the DMA copy_start; restarts the sequencer
- coord_valid  in  1  strobe, one cycle per delivered value (the DMA SEND phase)
- coord_in  in  16  clamped coordinate or color from the DMA
- xmask_raddr / xmask_waddr  out  XA_W  x-mask RAM read and write addresses
- xmask_rdata  in  16  x-mask RAM read data, 1-cycle latency
- xmask_wdata  out  16  x-mask RAM write data
- xmask_we  out  1  x-mask RAM write enable
- ymask_raddr / ymask_waddr / ymask_rdata / ymask_wdata / ymask_we  as x-mask, width YA_W
- color_waddr  out  6  color register index
- color_wdata  out  16  color value
- color_we  out  1  color write enable
- busy  out  1  high from frame_start until frame_done
- frame_done  out  1  one-cycle pulse after the last color is written
- overrun  out  1  sticky error flag; cleared by reset or frame_start

Behaviour:
- Reset: all outputs 0, all addresses 0; state IDLE, pass=LEFT, batch=0, index=0.
- Pass order is LEFT, RIGHT, TOP, BOTTOM, COLOR. Each pass consists of BATCHES batches of 16 values.
- State IDLE:
  - frame_start → LOAD; busy=1; overrun cleared.
  - coord_valid in IDLE is ignored.
- State LOAD:
  - Each coord_valid stores coord_in[9:0] into coord_reg[index]; index increments. Bits 15:10 are ignored in the coordinate passes.
  - In COLOR pass, values are not buffered. Each coord_valid writes straight through the same cycle: color_we=1, color_waddr={batch, index}, color_wdata=coord_in.
  - On the 16th value: index wraps to 0.
    - Coordinate pass → SWEEP, starting the next cycle.
    - COLOR pass → advance batch; after batch 3 → pulse frame_done, busy=0, go to IDLE.
- State SWEEP, position counter p runs 0..LIMIT-1 (LIMIT = X_RES for LEFT/RIGHT, Y_RES for TOP/BOTTOM):
  - Cycle t issues raddr = batch*LIMIT + p.
  - Cycle t+1 writes waddr = that same address.
  - Write data bit i, by pass:
    - LEFT: (p >= L_i); RAM contents ignored.
    - RIGHT: rdata[i] & (p < R_i).
    - TOP: (p >= T_i); RAM contents ignored.
    - BOTTOM: rdata[i] & (p < B_i).
  - Compares are unsigned 10-bit. Empty rects (R <= L) produce all-zero bits naturally.
  - Only the RAM of the current axis gets we; the other axis's we stays 0.
  - Sweep duration: LIMIT+1 cycles, which fits inside the DMA's LIMIT-cycle wait plus its 3-cycle value spacing.
  - After the last write: advance batch. After batch 3, advance pass and reset batch to 0. Return to LOAD.
- Boundaries:
  - Coordinate value 640 (or 480) is legal: LEFT mask all 0; RIGHT keeps all bits; TOP/BOTTOM likewise.
  - coord_valid during SWEEP: value dropped, overrun set, sweep continues unchanged.
  - frame_start in any non-IDLE state: abort at once; all we deasserted the same cycle; sequencer back to LEFT/batch 0/index 0 in LOAD; overrun cleared.
  - frame_start and coord_valid in the same cycle: frame_start wins; the value is not captured.
  - Reset mid-sweep: we drops the next cycle. Partial RAM contents are undefined until the next complete frame.

Decomposition:
- Shared package: pass enum (LEFT, RIGHT, TOP, BOTTOM, COLOR); X_RES, Y_RES, RECTS_PER_BATCH=16; BATCHES.
- One sub-module: span_compare16.
  - Inputs: 16×10-bit bounds, a 10-bit position, a ge/lt select, 16-bit old mask, and-enable.
  - Output: 16-bit mask.
  - Purely combinational; instantiated once.

Test Plan:
- Left/right mask: frame_start, LEFT batch0 = {0,10,639,640,…}, RIGHT batch0 = {640,20,640,640,…}.
  → x-mask at p=15: bit0=1, bit1=1, bit2=0, bit3=0. At p=639: bit2=1, bit3=0. At p=20: bit1=0.
- Empty rect: L=100, R=100 → bit clear at every x in batch 0.
- Full frame, 64 distinct colors:
  → color regfile index k holds value k+0x100.
  → frame_done pulses exactly once, one cycle after color 63 is written; busy falls the same cycle.
- Y path: T=0, B=480 in batch 3 slot 5 → ymask[3*480+p] bit5=1 for all p. xmask_we is never asserted during the Y passes.
- Overrun: coord_valid pulsed during a LEFT sweep at p=300 → overrun=1; sweep output unchanged; next batch still captures 16 values correctly.
- Abort: frame_start at RIGHT pass sweep p=200 → xmask_we=0 the next cycle; state LOAD/LEFT/batch 0; overrun=0; a following full frame produces correct masks.
